// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one CW-bit chunk per stage, valid/ready with a global stall.
// Optional subtract mode (A + ~B + 1) is compiled in with PIPE_ADDER_SUB_EN.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (STAGES < 1) ? 1 : WIDTH / STAGES;

  generate
    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be >= 1 and divisible by STAGES >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             advance;

  // Inversion is applied on entry, so the mode needs no per-stage storage.
`ifdef PIPE_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : ci;
`else
  assign b_eff = b;
  assign c_eff = ci;
`endif

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];

  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_d  [STAGES];
  logic             cy_q  [STAGES];
  logic             vld_d [STAGES];
  logic             vld_q [STAGES];
  logic             ovf_d;
  logic             ovf_q;

  always_comb begin
    src_a[0] = a;
    src_b[0] = b_eff;
    src_c[0] = c_eff;
    src_s[0] = '0;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = cy_q[k-1];
      src_s[k] = sum_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  // Operands shift down by one chunk per stage, so each stage always adds the low CW bits.
  always_comb begin : stage_logic
    logic [CW:0] part;
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, src_a[k][CW-1:0]} + {1'b0, src_b[k][CW-1:0]} + {{CW{1'b0}}, src_c[k]};
      vld_d[k] = src_v[k];
      cy_d[k]  = part[CW];
      sum_d[k] = src_s[k];
      sum_d[k][k*CW +: CW] = part[CW-1:0];
      a_d[k] = src_a[k] >> CW;
      b_d[k] = src_b[k] >> CW;
      if (k == STAGES - 1) begin
        ovf_d = (src_a[k][CW-1] == src_b[k][CW-1]) && (part[CW-1] != src_a[k][CW-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        cy_q[k]  <= cy_d[k];
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign co        = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, STAGES=4) with a queue scoreboard.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
`ifdef PIPE_ADDER_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
  logic        ovf;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  int          del_cyc[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          n_exp;
  logic        cur_sub = 1'b0;
  logic [15:0] hold_s;
  logic        hold_c;

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv);
    exp_t        e;
    logic [15:0] bb;
    logic        cc;
    logic [16:0] r;
    bb  = sv ? ~bv : bv;
    cc  = sv ? 1'b1 : cv;
    r   = {1'b0, av} + {1'b0, bb} + {16'd0, cc};
    e.s = r[15:0];
    e.c = r[16];
    e.o = (av[15] == bb[15]) && (r[15] != av[15]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic sv);
    a       = av;
    b       = bv;
    ci      = cv;
    cur_sub = sv;
`ifdef PIPE_ADDER_SUB_EN
    sub     = sv;
`endif
  endtask

  task automatic drive_rand();
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
  endtask

  // One clock: score what the coming edge delivers/accepts, then move past it.
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      del_cyc.push_back(cyc);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("co", co, e.c);
        chk("ovf", ovf, e.o);
      end
    end
    if (in_valid && in_ready) sb.push_back(model(a, b, ci, cur_sub));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    #8;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible after edge N+3.
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat_early", out_valid, 0);
      step();
    end
    chk("lat_valid", out_valid, 1);
    chk("lat_sum", sum, 16'h0100);
    chk("lat_co", co, 0);
    chk("lat_ovf", ovf, 0);
    drain();

    // Carry-out and signed overflow corners.
    in_valid = 1'b1;
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    step();
    drive(16'h8000, 16'h8000, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    drain();

    // Eight back-to-back operations at full throughput.
    del_cyc.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      chk("b2b_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", del_cyc.size(), 8);
    if (del_cyc.size() == 8) chk("b2b_consecutive", del_cyc[7] - del_cyc[0], 7);

    // Fill under backpressure, hold for three cycles, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10 && in_ready; i++) begin
      drive_rand();
      step();
    end
    drive_rand();
    chk("stall_full", out_valid, 1);
    chk("stall_in_ready0", in_ready, 0);
    hold_s = sum;
    hold_c = co;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_sum", sum, hold_s);
      chk("stall_co", co, hold_c);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    n_exp = sb.size() + 1;
    del_cyc.delete();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain();
    chk("release_count", del_cyc.size(), n_exp);
    if (del_cyc.size() > 0)
      chk("release_consecutive", del_cyc[del_cyc.size()-1] - del_cyc[0], n_exp - 1);

    // Reset with work in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_idle", out_valid, 0);
      step();
    end
    in_valid = 1'b1;
    drive(16'h1234, 16'h4321, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    drain();

`ifdef PIPE_ADDER_SUB_EN
    in_valid = 1'b1;
    drive(16'h0005, 16'h0007, 1'b0, 1'b1);
    step();
    drive(16'h0007, 16'h0005, 1'b1, 1'b1);
    step();
    drive(16'h8000, 16'h0001, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    drain();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
